// File: rtl/convolver_pkg.sv
// Shared convolver constants and fixed-point helpers.
// Used by the adder tree, MAC and activation blocks.
package convolver_pkg;

    localparam int FRAC_BITS = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Entries left after lvl rounds of pairwise reduction of n operands.
    function automatic int level_count(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

    function automatic logic fits_width(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v <= hi) && (v >= lo);
    endfunction

    function automatic logic signed [63:0] sat_to_width(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the pairwise adder tree.
// Odd trailing entry passes through unchanged.
module adder_tree_level #(
    parameter int N_IN  = 2,
    parameter int SUM_W = 21,
    localparam int N_OUT = (N_IN + 1) / 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic                   i_valid,
    input  logic [N_IN*SUM_W-1:0]  i_data,
    output logic                   o_valid,
    output logic [N_OUT*SUM_W-1:0] o_data
);

    logic [N_OUT*SUM_W-1:0] w_sum;
    logic [N_OUT*SUM_W-1:0] r_data;
    logic                   r_valid;

    for (genvar i = 0; i < N_OUT; i++) begin : g_pair
        if (2 * i + 1 < N_IN) begin : g_add
            assign w_sum[i*SUM_W +: SUM_W] =
                i_data[(2*i)*SUM_W +: SUM_W] +
                i_data[(2*i+1)*SUM_W +: SUM_W];
        end else begin : g_pass
            assign w_sum[i*SUM_W +: SUM_W] =
                i_data[(2*i)*SUM_W +: SUM_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_sum;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree: NUM_INPUTS operands plus bias,
// exact guard-bit sum, then saturate/wrap register with overflow flag.
module pipelined_adder_tree
    import convolver_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 25,
    parameter int SATURATE   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0]          bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          result,
    output logic                           overflow
);

    localparam int N      = NUM_INPUTS + 1;
    localparam int LEVELS = clog2(N);
    localparam int SUM_W  = DATA_WIDTH + LEVELS;

    logic [N*SUM_W-1:0]     w_ops;
    logic                   w_advance;
    logic signed [SUM_W-1:0] w_sum;
    logic                   w_sum_valid;
    logic [DATA_WIDTH-1:0]  w_res;
    logic                   w_ovf;

    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_overflow;

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_ext
        assign w_ops[k*SUM_W +: SUM_W] = {
            {LEVELS{data_in[k*DATA_WIDTH + DATA_WIDTH - 1]}},
            data_in[k*DATA_WIDTH +: DATA_WIDTH]
        };
    end

    assign w_ops[NUM_INPUTS*SUM_W +: SUM_W] =
        {{LEVELS{bias[DATA_WIDTH-1]}}, bias};

    // Whole pipe moves as one; a stalled output freezes every level.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int CNT_IN  = level_count(N, l);
        localparam int CNT_OUT = level_count(N, l + 1);

        logic [CNT_IN*SUM_W-1:0]  w_in;
        logic                     w_vin;
        logic [CNT_OUT*SUM_W-1:0] w_out;
        logic                     w_vout;

        if (l == 0) begin : g_first
            assign w_in  = w_ops;
            assign w_vin = in_valid;
        end else begin : g_next
            assign w_in  = g_lvl[l-1].w_out;
            assign w_vin = g_lvl[l-1].w_vout;
        end

        adder_tree_level #(
            .N_IN  (CNT_IN),
            .SUM_W (SUM_W)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_advance),
            .i_valid (w_vin),
            .i_data  (w_in),
            .o_valid (w_vout),
            .o_data  (w_out)
        );
    end

    assign w_sum       = g_lvl[LEVELS-1].w_out;
    assign w_sum_valid = g_lvl[LEVELS-1].w_vout;
    assign w_ovf       = !fits_width(64'(w_sum), DATA_WIDTH);

    if (SATURATE != 0) begin : g_sat
        assign w_res = DATA_WIDTH'(sat_to_width(64'(w_sum), DATA_WIDTH));
    end else begin : g_wrap
        assign w_res = w_sum[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= w_sum_valid;
            r_result    <= w_res;
            r_overflow  <= w_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree: table vectors,
// random streams against an integer reference, stall and reset cases.
module tb_pipelined_adder_tree;

    localparam int DW = 16;
    localparam int NI = 25;
    localparam int N9 = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [NI*DW-1:0] data_in;
    logic [N9*DW-1:0] data9;
    logic [DW-1:0]    bias;

    logic          in_ready, out_valid, overflow;
    logic [DW-1:0] result;
    logic          w_in_ready, w_out_valid, w_overflow;
    logic [DW-1:0] w_result;
    logic          n9_in_ready, n9_out_valid, n9_overflow;
    logic [DW-1:0] n9_result;

    pipelined_adder_tree #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .SATURATE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    pipelined_adder_tree #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .data_in(data_in), .bias(bias), .out_valid(w_out_valid),
        .out_ready(out_ready), .result(w_result), .overflow(w_overflow)
    );

    pipelined_adder_tree #(.DATA_WIDTH(DW), .NUM_INPUTS(N9), .SATURATE(1)) u_n9 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n9_in_ready),
        .data_in(data9), .bias(bias), .out_valid(n9_out_valid),
        .out_ready(out_ready), .result(n9_result), .overflow(n9_overflow)
    );

    typedef struct {
        logic [15:0] rs;
        logic        ov;
        logic [15:0] rw;
        int          t;
    } exp_t;

    typedef struct {
        int          op;
        int          b;
        logic [15:0] rs;
        logic        ov;
        logic [15:0] rw;
    } row_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_push  = 0;
    int   n_pop   = 0;
    bit   exact_lat;
    bit   accepted;
    int   cur_ops[NI];
    int   cur_bias;
    exp_t q[$];
    row_t rows[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int   s;
        int   c;
        s = cur_bias;
        for (int i = 0; i < NI; i++) s += cur_ops[i];
        c = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        e.ov = (s > 32767) || (s < -32768);
        e.rs = 16'(c);
        e.rw = 16'(s);
        e.t  = 0;
        return e;
    endfunction

    function automatic int rand_op();
        if ($urandom_range(0, 1) == 1)
            return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    task automatic drive();
        for (int i = 0; i < NI; i++) data_in[i*DW +: DW] = 16'(cur_ops[i]);
        bias = 16'(cur_bias);
    endtask

    task automatic randomize_vec();
        for (int i = 0; i < NI; i++) cur_ops[i] = rand_op();
        cur_bias = rand_op();
        drive();
    endtask

    // One clock: scoreboard push/pop mid-cycle, then advance to next negedge.
    task automatic tick();
        exp_t e;
        #1;
        accepted = in_valid && in_ready;
        if (accepted) begin
            e   = model();
            e.t = cyc;
            q.push_back(e);
            n_push++;
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected none", result);
            end else begin
                e = q.pop_front();
                n_pop++;
                check("result_sat", 32'(result), 32'(e.rs));
                check("ovf_sat", 32'(overflow), 32'(e.ov));
                check("result_wrap", 32'(w_result), 32'(e.rw));
                check("ovf_wrap", 32'(w_overflow), 32'(e.ov));
                if (exact_lat) check("latency", 32'(cyc - e.t), 32'd6);
                else if (cyc - e.t < 6) check("latency_min", 32'(cyc - e.t), 32'd6);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [15:0] hold_r;
        logic        hold_o;
        int          lat;
        int          pops0;

        rows[0] = '{256, 256, 16'h1A00, 1'b0, 16'h1A00};
        rows[1] = '{32767, 32767, 16'h7FFF, 1'b1, 16'hFFE6};
        rows[2] = '{-32768, -32768, 16'h8000, 1'b1, 16'h0000};
        rows[3] = '{-1, 5, 16'hFFEC, 1'b0, 16'hFFEC};
        rows[4] = '{1310, 17, 16'h7FFF, 1'b0, 16'h7FFF};
        rows[5] = '{1310, 18, 16'h7FFF, 1'b1, 16'h8000};
        rows[6] = '{-1310, -18, 16'h8000, 1'b0, 16'h8000};
        rows[7] = '{-1310, -19, 16'h8000, 1'b1, 16'h7FFF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        data9     = '0;
        bias      = '0;
        exact_lat = 1'b1;
        for (int i = 0; i < NI; i++) cur_ops[i] = 0;
        cur_bias = 0;

        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Table vectors, one at a time
        foreach (rows[r]) begin
            for (int i = 0; i < NI; i++) cur_ops[i] = rows[r].op;
            cur_bias = rows[r].b;
            drive();
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                tick();
                lat++;
            end
            check("tbl_latency", 32'(lat), 32'd6);
            check("tbl_result_sat", 32'(result), 32'(rows[r].rs));
            check("tbl_ovf", 32'(overflow), 32'(rows[r].ov));
            check("tbl_result_wrap", 32'(w_result), 32'(rows[r].rw));
            tick();
        end

        // Back-to-back random vectors
        pops0 = n_pop;
        for (int v = 0; v < 10; v++) begin
            randomize_vec();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int v = 0; v < 8; v++) tick();
        check("b2b_count", 32'(n_pop - pops0), 32'd10);
        check("b2b_queue_empty", 32'(q.size()), 32'd0);

        // Stream with a 4-cycle output stall
        exact_lat = 1'b0;
        accepted  = 1'b1;
        hold_r    = '0;
        hold_o    = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (accepted) randomize_vec();
            in_valid  = 1'b1;
            out_ready = !(t >= 8 && t < 12);
            #1;
            if (t == 8) begin
                check("stall_out_valid", 32'(out_valid), 32'd1);
                hold_r = result;
                hold_o = overflow;
            end
            if (t >= 8 && t < 12) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_result_held", 32'(result), 32'(hold_r));
                check("stall_ovf_held", 32'(overflow), 32'(hold_o));
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int v = 0; v < 10; v++) tick();
        check("stall_no_loss", 32'(n_pop), 32'(n_push));
        check("stall_queue_empty", 32'(q.size()), 32'd0);

        // Reset with vectors in flight
        exact_lat = 1'b1;
        for (int v = 0; v < 8; v++) begin
            randomize_vec();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        pops0 = n_pop;
        randomize_vec();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int v = 0; v < 8; v++) tick();
        check("post_rst_count", 32'(n_pop - pops0), 32'd1);

        // NUM_INPUTS=9 instance: 1..9 plus bias -45
        for (int i = 0; i < NI; i++) cur_ops[i] = 0;
        cur_bias = -45;
        drive();
        for (int i = 0; i < N9; i++) data9[i*DW +: DW] = 16'(i + 1);
        in_valid = 1'b1;
        #1;
        check("n9_in_ready", 32'(n9_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!n9_out_valid && lat < 12) begin
            tick();
            lat++;
        end
        check("n9_latency", 32'(lat), 32'd5);
        check("n9_result", 32'(n9_result), 32'd0);
        check("n9_overflow", 32'(n9_overflow), 32'd0);
        for (int v = 0; v < 4; v++) tick();
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
